// File: rtl/v_instr_queue.sv
// -----------------------------------------------------------------------------
// v_instr_queue
//
// Vector instruction queue and issue stage sitting directly in front of the
// vector decoder. The scalar core pushes vector instructions together with
// their scalar rs1/rs2 operand values. Only vector opcodes (OP-V, LOAD-FP,
// STORE-FP) are buffered; anything else is dropped. One instruction at a
// time is presented to the decoder and held stable until ex_done.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   push_valid    scalar core presents an instruction
//   push_instr    raw 32-bit instruction word
//   push_rs1/rs2  scalar operand values travelling with the instruction
//   push_ready    queue can accept an entry (not full)
//   flush         discard every queued and in-flight instruction
//   ex_done       single-cycle completion pulse for the issued instruction
//   instr         issued instruction (0 when nothing is issued)
//   rs1_data      rs1 value of the issued instruction
//   rs2_data      rs2 value of the issued instruction
//   issue_valid   pulse in the first cycle a new instruction is presented
//   busy          an instruction is issued and not yet completed
//   drop          pulse: the previously accepted word was not a vector op
//   count         FIFO occupancy, excluding the issued instruction
// -----------------------------------------------------------------------------
module v_instr_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [31:0]      push_instr,
  input  logic [31:0]      push_rs1,
  input  logic [31:0]      push_rs2,
  output logic             push_ready,
  input  logic             flush,
  input  logic             ex_done,
  output logic [31:0]      instr,
  output logic [31:0]      rs1_data,
  output logic [31:0]      rs2_data,
  output logic             issue_valid,
  output logic             busy,
  output logic             drop,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  function automatic logic is_vec_opcode(input logic [6:0] opc);
    return (opc == 7'b1010111) || (opc == 7'b0000111) || (opc == 7'b0100111);
  endfunction

  // Entry storage is pure data and is never reset; validity is tracked by the
  // pointers and the occupancy counter.
  logic [31:0] mem_instr_q [DEPTH];
  logic [31:0] mem_rs1_q   [DEPTH];
  logic [31:0] mem_rs2_q   [DEPTH];

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic             issue_valid_q, issue_valid_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;

  logic empty;
  logic full;
  logic push_fire;
  logic wr_en;
  logic pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign push_ready = !full;

  // A handshake that completes with a non-vector opcode still consumes the
  // word from the core; it is simply not stored.
  assign push_fire = push_valid && push_ready && !flush;
  assign wr_en     = push_fire && is_vec_opcode(push_instr[6:0]);

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    pop      = 1'b0;
    drop_d   = push_fire && !is_vec_opcode(push_instr[6:0]);

    // Emptiness is judged on the registered count, so an entry written this
    // cycle cannot be popped before the next one.
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (ex_done) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            instr_d = '0;
            rs1_d   = '0;
            rs2_d   = '0;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        instr_d = '0;
        rs1_d   = '0;
        rs2_d   = '0;
      end
    endcase

    if (pop) begin
      state_d = S_ISSUE;
      instr_d = mem_instr_q[rd_ptr_q];
      rs1_d   = mem_rs1_q[rd_ptr_q];
      rs2_d   = mem_rs2_q[rd_ptr_q];
    end

    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flush wins over everything: abandon the issued instruction and the queue.
    if (flush) begin
      state_d  = S_IDLE;
      instr_d  = '0;
      rs1_d    = '0;
      rs2_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    issue_valid_d = (state_d == S_ISSUE);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      instr_q       <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      issue_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      instr_q       <= instr_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      issue_valid_q <= issue_valid_d;
      busy_q        <= busy_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_instr_q[wr_ptr_q] <= push_instr;
      mem_rs1_q[wr_ptr_q]   <= push_rs1;
      mem_rs2_q[wr_ptr_q]   <= push_rs2;
    end
  end

  assign instr       = instr_q;
  assign rs1_data    = rs1_q;
  assign rs2_data    = rs2_q;
  assign issue_valid = issue_valid_q;
  assign busy        = busy_q;
  assign drop        = drop_q;
  assign count       = count_q;

endmodule

// File: tb/tb_v_instr_queue.sv
// -----------------------------------------------------------------------------
// tb_v_instr_queue
//
// Self-checking bench for v_instr_queue. A behavioural model (a queue of
// pending entries plus the currently held instruction) predicts every output
// after each clock edge; scenario tasks also check hand-derived constants.
// -----------------------------------------------------------------------------
module tb_v_instr_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pv  = 1'b0;
  logic [31:0]      pi  = '0;
  logic [31:0]      pr1 = '0;
  logic [31:0]      pr2 = '0;
  logic             fl  = 1'b0;
  logic             exd = 1'b0;
  logic             push_ready;
  logic [31:0]      instr;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic             issue_valid;
  logic             busy;
  logic             drop;
  logic [CNT_W-1:0] count;

  v_instr_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .push_valid(pv), .push_instr(pi), .push_rs1(pr1),
    .push_rs2(pr2), .push_ready(push_ready), .flush(fl), .ex_done(exd),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .busy(busy), .drop(drop), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] r1;
    logic [31:0] r2;
  } ent_t;

  // Reference model state.
  ent_t         mq[$];
  ent_t         cur;
  logic         have  = 1'b0;
  logic         fresh = 1'b0;
  logic         dropm = 1'b0;
  logic [102:0] exp_vec = '0;
  logic [102:0] act_vec;

  assign act_vec = {instr, rs1_data, rs2_data, issue_valid, busy, drop, count, push_ready};

  function automatic logic is_vec(input logic [6:0] o);
    return (o == 7'b1010111) || (o == 7'b0000111) || (o == 7'b0100111);
  endfunction

  function automatic logic [31:0] rand_instr(input logic vec);
    logic [31:0] w;
    logic [6:0]  o;
    w = $urandom;
    if (vec) begin
      case ($urandom_range(0, 2))
        0:       o = 7'b1010111;
        1:       o = 7'b0000111;
        default: o = 7'b0100111;
      endcase
    end else begin
      o = 7'($urandom_range(0, 127));
      if (is_vec(o)) o = 7'b0010011;
    end
    w[6:0] = o;
    return w;
  endfunction

  // Advance one clock, update the model from the inputs seen at the edge,
  // then settle 1 time unit so outputs can be sampled away from the edge.
  task automatic tick();
    int   n;
    logic acc;
    ent_t e;
    @(posedge clk);
    if (rst || fl) begin
      mq.delete();
      have  = 1'b0;
      fresh = 1'b0;
      dropm = 1'b0;
    end else begin
      n     = mq.size();
      acc   = pv && (n < DEPTH);
      dropm = acc && !is_vec(pi[6:0]);
      if (!have) begin
        if (n > 0) begin
          cur   = mq.pop_front();
          have  = 1'b1;
          fresh = 1'b1;
        end else begin
          fresh = 1'b0;
        end
      end else if (exd) begin
        if (n > 0) begin
          cur   = mq.pop_front();
          fresh = 1'b1;
        end else begin
          have  = 1'b0;
          fresh = 1'b0;
        end
      end else begin
        fresh = 1'b0;
      end
      if (acc && is_vec(pi[6:0])) begin
        e.i  = pi;
        e.r1 = pr1;
        e.r2 = pr2;
        mq.push_back(e);
      end
    end
    exp_vec = {(have ? cur.i : 32'h0), (have ? cur.r1 : 32'h0), (have ? cur.r2 : 32'h0),
               fresh, have, dropm, CNT_W'(mq.size()), (mq.size() < DEPTH)};
    #1;
  endtask

  task automatic idle_inputs();
    pv  = 1'b0;
    fl  = 1'b0;
    exd = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pv  = 1'b1;
    pi  = rand_instr(1'b1);
    tick();
    tick();
    idle_inputs();
    checks++;
    if (act_vec !== {96'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state act=%h exp=%h", act_vec, {96'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
    end
  endtask

  task automatic test_single();
    logic [31:0] r1, r2;
    r1 = $urandom;
    r2 = $urandom;
    pv = 1'b1; pi = 32'h022080D7; pr1 = r1; pr2 = r2;
    tick();
    pv = 1'b0;
    checks++;
    if (count !== 3'd1 || instr !== 32'h0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_queued count=%0d instr=%h iv=%b exp 1/0/0", count, instr, issue_valid);
    end
    tick();
    checks++;
    if (instr !== 32'h022080D7 || issue_valid !== 1'b1 || busy !== 1'b1 ||
        rs1_data !== r1 || rs2_data !== r2 || count !== 3'd0) begin
      errors++;
      $display("FAIL single_issue instr=%h iv=%b busy=%b rs1=%h rs2=%h exp %h/1/1/%h/%h",
               instr, issue_valid, busy, rs1_data, rs2_data, 32'h022080D7, r1, r2);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (instr !== 32'h022080D7 || issue_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_hold instr=%h iv=%b busy=%b exp 022080d7/0/1", instr, issue_valid, busy);
      end
    end
    exd = 1'b1;
    tick();
    exd = 1'b0;
    checks++;
    if (instr !== 32'h0 || busy !== 1'b0 || rs1_data !== 32'h0 || act_vec !== exp_vec) begin
      errors++;
      $display("FAIL single_done instr=%h busy=%b rs1=%h exp 0/0/0", instr, busy, rs1_data);
    end
  endtask

  task automatic test_full();
    logic [31:0] b_instr;
    b_instr = '0;
    for (int k = 0; k < 5; k++) begin
      pv = 1'b1; pi = rand_instr(1'b1); pr1 = $urandom; pr2 = $urandom;
      if (k == 1) b_instr = pi;
      tick();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL full_fill k=%0d act=%h exp=%h", k, act_vec, exp_vec);
      end
      if (k == 3) begin
        checks++;
        if (count !== 3'd3 || busy !== 1'b1) begin
          errors++;
          $display("FAIL full_count3 count=%0d busy=%b exp 3/1", count, busy);
        end
      end
    end
    checks++;
    if (count !== 3'd4 || push_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready count=%0d ready=%b exp 4/0", count, push_ready);
    end
    pi = rand_instr(1'b1); pr1 = $urandom;
    repeat (2) begin
      tick();
      checks++;
      if (count !== 3'd4 || act_vec !== exp_vec) begin
        errors++;
        $display("FAIL full_refuse count=%0d act=%h exp=%h", count, act_vec, exp_vec);
      end
    end
    exd = 1'b1;
    tick();
    exd = 1'b0;
    pv  = 1'b0;
    checks++;
    if (push_ready !== 1'b1 || count !== 3'd3 || issue_valid !== 1'b1 || instr !== b_instr) begin
      errors++;
      $display("FAIL full_pop ready=%b count=%0d iv=%b instr=%h exp 1/3/1/%h",
               push_ready, count, issue_valid, instr, b_instr);
    end
    for (int c = 0; c < 40 && (have || mq.size() != 0); c++) begin
      exd = have;
      tick();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL full_drain act=%h exp=%h", act_vec, exp_vec);
      end
    end
    idle_inputs();
    checks++;
    if (have || mq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_drain_timeout busy=%b count=%0d exp 0/0", busy, count);
    end
  endtask

  task automatic test_drop();
    pv = 1'b1; pi = 32'h00100093; pr1 = $urandom; pr2 = $urandom;
    tick();
    pv = 1'b0;
    checks++;
    if (drop !== 1'b1 || count !== 3'd0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL drop_pulse drop=%b count=%0d instr=%h exp 1/0/0", drop, count, instr);
    end
    repeat (2) begin
      tick();
      checks++;
      if (drop !== 1'b0 || count !== 3'd0 || instr !== 32'h0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL drop_after drop=%b count=%0d instr=%h busy=%b exp 0/0/0/0",
                 drop, count, instr, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ei[3], e1[3], e2[3];
    int k, last;
    k = 0;
    last = -10;
    for (int j = 0; j < 3; j++) begin
      ei[j] = rand_instr(1'b1); e1[j] = $urandom; e2[j] = $urandom;
    end
    for (int c = 0; c < 12; c++) begin
      pv = (c < 3);
      if (c < 3) begin pi = ei[c]; pr1 = e1[c]; pr2 = e2[c]; end
      exd = fresh;
      tick();
      if (issue_valid === 1'b1) begin
        checks++;
        if (k >= 3 || instr !== ei[k] || rs1_data !== e1[k] || rs2_data !== e2[k] ||
            (k > 0 && c != last + 1)) begin
          errors++;
          $display("FAIL b2b_issue k=%0d c=%0d last=%0d instr=%h rs1=%h rs2=%h", k, c, last,
                   instr, rs1_data, rs2_data);
        end
        last = c;
        k++;
      end
    end
    idle_inputs();
    checks++;
    if (k != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_total issued=%0d busy=%b exp 3/0", k, busy);
    end
  endtask

  task automatic test_flush();
    for (int j = 0; j < 3; j++) begin
      pv = 1'b1; pi = rand_instr(1'b1); pr1 = $urandom; pr2 = $urandom;
      tick();
    end
    checks++;
    if (busy !== 1'b1 || issue_valid !== 1'b0 || count !== 3'd2) begin
      errors++;
      $display("FAIL flush_setup busy=%b iv=%b count=%0d exp 1/0/2", busy, issue_valid, count);
    end
    fl = 1'b1; pv = 1'b1; pi = rand_instr(1'b1);
    tick();
    idle_inputs();
    checks++;
    if (count !== 3'd0 || instr !== 32'h0 || busy !== 1'b0 || drop !== 1'b0 || rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL flush_clear count=%0d instr=%h busy=%b drop=%b rs1=%h exp 0/0/0/0/0",
               count, instr, busy, drop, rs1_data);
    end
    repeat (3) begin
      tick();
      checks++;
      if (issue_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin
        errors++;
        $display("FAIL flush_absent iv=%b busy=%b count=%0d exp 0/0/0", issue_valid, busy, count);
      end
    end
  endtask

  task automatic test_wrap();
    int sent, got;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 400; c++) begin
      if (got == 10 && !have && mq.size() == 0) break;
      pv  = (sent < 10) && ($urandom_range(0, 1) == 1);
      pi  = rand_instr(1'b1);
      pr1 = 32'(sent + 1);
      pr2 = $urandom;
      exd = ($urandom_range(0, 2) == 0);
      if (pv && mq.size() < DEPTH) sent++;
      tick();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL wrap_model act=%h exp=%h", act_vec, exp_vec);
      end
      if (issue_valid === 1'b1) begin
        checks++;
        if (rs1_data !== 32'(got + 1)) begin
          errors++;
          $display("FAIL wrap_order rs1=%0d exp %0d", rs1_data, got + 1);
        end
        got++;
      end
    end
    idle_inputs();
    checks++;
    if (got != 10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_total issued=%0d busy=%b exp 10/0", got, busy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      fl  = ($urandom_range(0, 29) == 0);
      pv  = ($urandom_range(0, 1) == 1);
      pi  = rand_instr($urandom_range(0, 3) != 0);
      pr1 = $urandom;
      pr2 = $urandom;
      exd = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL random c=%0d act=%h exp=%h", c, act_vec, exp_vec);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_full();
    test_drop();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
